// File: rtl/imem_if_resp_pkg.sv
// Shared IF <-> IMEM definitions: data width, NOP encoding, port structs and
// the responder state encoding.
package imem_if_resp_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            req;
  } type_if2mem_s;

  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] r_data;
  } type_mem2if_s;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } type_imem_resp_state_e;

endpackage

// File: rtl/imem_if_resp.sv
// Instruction-memory responder: turns per-cycle fetch address requests into
// synchronous SRAM reads, inserts WAIT_STATES stall cycles, restarts on fetch
// redirects while stalled and answers out-of-range fetches with a faulting NOP.
module imem_if_resp
  import imem_if_resp_pkg::*;
#(
  parameter logic [XLEN-1:0] IMEM_BASE   = 32'h8000_0000,
  parameter int unsigned     IMEM_DEPTH  = 4096,
  parameter int unsigned     WAIT_STATES = 0,
  localparam int unsigned    AW          = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  type_if2mem_s  if2mem_i,
  output type_mem2if_s  mem2if_o,
  output logic          sram_rd_o,
  output logic [AW-1:0] sram_addr_o,
  input  logic [XLEN-1:0] sram_rdata_i,
  output logic          fault_o
);

  localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(IMEM_DEPTH) << 2;
  localparam logic [3:0]      WS_LOAD    = 4'(WAIT_STATES);
  localparam type_imem_resp_state_e FIRST_STATE = (WAIT_STATES > 0) ? BUSY : DONE;

  type_imem_resp_state_e state_q, state_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic            pend_oor_q, pend_oor_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] data_buf_q, data_buf_d;
  logic            fresh_q, fresh_d;
  logic [AW-1:0]   sram_addr_q, sram_addr_d;

  logic [XLEN-1:0] offset;
  logic            in_range;
  logic [AW-1:0]   word_idx;
  logic            kill;
  logic            accept;

  // Address decode, redirect detection and accept qualification.
  always_comb begin
    offset   = if2mem_i.addr - IMEM_BASE;
    in_range = offset < IMEM_BYTES;
    word_idx = offset[AW+1:2];
    kill     = (state_q == BUSY) && (if2mem_i.addr != pend_addr_q);
    // Gated by rst_n so the read strobe is already quiet while reset is held.
    accept   = rst_n && if2mem_i.req && ((state_q != BUSY) || kill);
  end

  // Next-state and pending-access bookkeeping.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_oor_d  = pend_oor_q;
    cnt_d       = cnt_q;
    data_buf_d  = data_buf_q;
    fresh_d     = accept;
    sram_addr_d = sram_addr_q;

    // SRAM data for the latest accept is valid exactly one cycle later.
    if ((state_q == BUSY) && fresh_q) begin
      data_buf_d = sram_rdata_i;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = FIRST_STATE;
      end
      BUSY: begin
        if (accept) begin
          state_d = BUSY;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = DONE;
        end
      end
      DONE: begin
        if (accept) state_d = FIRST_STATE;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      pend_addr_d = if2mem_i.addr;
      pend_oor_d  = ~in_range;
      cnt_d       = WS_LOAD;
      if (in_range) sram_addr_d = word_idx;
    end
  end

  // Output decode: SRAM strobe/address and the fetch response.
  always_comb begin
    sram_rd_o       = accept && in_range;
    sram_addr_o     = sram_rd_o ? word_idx : sram_addr_q;
    mem2if_o.ack    = (state_q == DONE);
    mem2if_o.r_data = INSTR_NOP;
    fault_o         = (state_q == DONE) && pend_oor_q;
    if ((state_q == DONE) && !pend_oor_q) begin
      mem2if_o.r_data = (WAIT_STATES == 0) ? sram_rdata_i : data_buf_q;
    end
  end

  // State and pending-access registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      pend_oor_q  <= 1'b0;
      cnt_q       <= '0;
      data_buf_q  <= '0;
      fresh_q     <= 1'b0;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_oor_q  <= pend_oor_d;
      cnt_q       <= cnt_d;
      data_buf_q  <= data_buf_d;
      fresh_q     <= fresh_d;
      sram_addr_q <= sram_addr_d;
    end
  end

endmodule

// File: tb/tb_imem_if_resp.sv
// Bench for imem_if_resp: three responders (0, 2 and 3 wait states) each
// backed by a behavioural synchronous SRAM with a known fill pattern.
module tb_imem_if_resp;
  import imem_if_resp_pkg::*;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned AW    = 12;

  logic clk = 1'b0;
  logic rst_n;

  type_if2mem_s  in0, in2, in3;
  type_mem2if_s  out0, out2, out3;
  logic          rd0, rd2, rd3;
  logic [AW-1:0] sa0, sa2, sa3;
  logic [31:0]   rdat0, rdat2, rdat3;
  logic          f0, f2, f3;

  logic [31:0] mem [DEPTH];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [31:0]   addr;
    logic          req;
    logic          ack;
    logic [31:0]   data;
    logic          fault;
    logic          rd;
    logic [AW-1:0] saddr;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  imem_if_resp #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .if2mem_i(in0), .mem2if_o(out0),
    .sram_rd_o(rd0), .sram_addr_o(sa0), .sram_rdata_i(rdat0), .fault_o(f0));

  imem_if_resp #(.WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n), .if2mem_i(in2), .mem2if_o(out2),
    .sram_rd_o(rd2), .sram_addr_o(sa2), .sram_rdata_i(rdat2), .fault_o(f2));

  imem_if_resp #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .if2mem_i(in3), .mem2if_o(out3),
    .sram_rd_o(rd3), .sram_addr_o(sa3), .sram_rdata_i(rdat3), .fault_o(f3));

  // Behavioural synchronous SRAMs: data one cycle after the read strobe, held otherwise.
  always @(posedge clk) if (rd0) rdat0 <= mem[sa0];
  always @(posedge clk) if (rd2) rdat2 <= mem[sa2];
  always @(posedge clk) if (rd3) rdat3 <= mem[sa3];

  function automatic logic [31:0] mem_val(input int unsigned idx);
    return (idx == 0) ? 32'h0000_0013 : (32'hC0DE_0000 | 32'(idx));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = mem_val(i);
    rdat0 = '0; rdat2 = '0; rdat3 = '0;

    //             addr           req   ack   data            flt   rd    saddr
    tbl[0]  = '{32'h8000_0000, 1'b1, 1'b0, INSTR_NOP,      1'b0, 1'b1, 12'd0};
    tbl[1]  = '{32'h8000_0004, 1'b1, 1'b1, mem_val(0),     1'b0, 1'b1, 12'd1};
    tbl[2]  = '{32'h8000_0008, 1'b1, 1'b1, mem_val(1),     1'b0, 1'b1, 12'd2};
    tbl[3]  = '{32'h8000_4000, 1'b1, 1'b1, mem_val(2),     1'b0, 1'b0, 12'd2};
    tbl[4]  = '{32'h8000_000C, 1'b1, 1'b1, INSTR_NOP,      1'b1, 1'b1, 12'd3};
    tbl[5]  = '{32'h8000_000C, 1'b0, 1'b1, mem_val(3),     1'b0, 1'b0, 12'd3};
    tbl[6]  = '{32'h8000_000C, 1'b0, 1'b0, INSTR_NOP,      1'b0, 1'b0, 12'd3};
    tbl[7]  = '{32'h7FFF_FFFC, 1'b1, 1'b0, INSTR_NOP,      1'b0, 1'b0, 12'd3};
    tbl[8]  = '{32'h7FFF_FFFC, 1'b0, 1'b1, INSTR_NOP,      1'b1, 1'b0, 12'd3};
    tbl[9]  = '{32'h8000_3FFC, 1'b1, 1'b0, INSTR_NOP,      1'b0, 1'b1, 12'd4095};
    tbl[10] = '{32'h8000_3FFC, 1'b0, 1'b1, mem_val(4095),  1'b0, 1'b0, 12'd4095};

    // Reset held with a request already presented.
    rst_n = 1'b0;
    in0 = '{addr: 32'h8000_0000, req: 1'b1};
    in2 = '{addr: 32'h0, req: 1'b0};
    in3 = '{addr: 32'h0, req: 1'b0};
    #2;
    chk("reset.ack",   32'(out0.ack), 32'd0);
    chk("reset.rdata", out0.r_data,   INSTR_NOP);
    chk("reset.fault", 32'(f0),       32'd0);
    chk("reset.rd",    32'(rd0),      32'd0);
    chk("reset.saddr", 32'(sa0),      32'd0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait streaming, out-of-range and boundary addresses.
    for (int i = 0; i < 11; i++) begin
      in0.addr = tbl[i].addr;
      in0.req  = tbl[i].req;
      #1;
      chk($sformatf("ws0[%0d].ack", i),   32'(out0.ack), 32'(tbl[i].ack));
      chk($sformatf("ws0[%0d].data", i),  out0.r_data,   tbl[i].data);
      chk($sformatf("ws0[%0d].fault", i), 32'(f0),       32'(tbl[i].fault));
      chk($sformatf("ws0[%0d].rd", i),    32'(rd0),      32'(tbl[i].rd));
      chk($sformatf("ws0[%0d].saddr", i), 32'(sa0),      32'(tbl[i].saddr));
      @(posedge clk); #1;
    end
    in0.req = 1'b0;

    // Two wait states, address held through the stall.
    in2 = '{addr: 32'h8000_0010, req: 1'b1};
    #1;
    chk("ws2.c0.rd",    32'(rd2),      32'd1);
    chk("ws2.c0.saddr", 32'(sa2),      32'd4);
    chk("ws2.c0.ack",   32'(out2.ack), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #2;
      chk($sformatf("ws2.c%0d.ack", k), 32'(out2.ack), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) chk($sformatf("ws2.c%0d.rd", k), 32'(rd2), 32'd0);
    end
    chk("ws2.c3.data",  out2.r_data, mem_val(4));
    chk("ws2.c3.fault", 32'(f2),     32'd0);
    in2.req = 1'b0;
    @(posedge clk); #2;
    chk("ws2.c4.ack", 32'(out2.ack), 32'd0);

    // Three wait states with a redirect one cycle into the stall.
    in3 = '{addr: 32'h8000_0020, req: 1'b1};
    #1;
    chk("kill.c0.rd",    32'(rd3), 32'd1);
    chk("kill.c0.saddr", 32'(sa3), 32'd8);
    @(posedge clk); #1;
    in3.addr = 32'h8000_0100;
    #1;
    chk("kill.c1.rd",    32'(rd3),      32'd1);
    chk("kill.c1.saddr", 32'(sa3),      32'h40);
    chk("kill.c1.ack",   32'(out3.ack), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #2;
      chk($sformatf("kill.+%0d.ack", k), 32'(out3.ack), (k == 4) ? 32'd1 : 32'd0);
      if (k < 4) chk($sformatf("kill.+%0d.rd", k), 32'(rd3), 32'd0);
    end
    chk("kill.data", out3.r_data, mem_val(32'h40));
    in3.req = 1'b0;
    @(posedge clk); #2;
    chk("kill.after.ack", 32'(out3.ack), 32'd0);

    // Asynchronous reset while ws3 is stalled and ws0 is acking.
    in3 = '{addr: 32'h8000_0030, req: 1'b1};
    in0 = '{addr: 32'h8000_0000, req: 1'b1};
    @(posedge clk); #1;
    chk("arst.pre.ack0", 32'(out0.ack), 32'd1);
    chk("arst.pre.ack3", 32'(out3.ack), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.ack0",   32'(out0.ack), 32'd0);
    chk("arst.data0",  out0.r_data,   INSTR_NOP);
    chk("arst.rd0",    32'(rd0),      32'd0);
    chk("arst.ack3",   32'(out3.ack), 32'd0);
    chk("arst.data3",  out3.r_data,   INSTR_NOP);
    chk("arst.fault3", 32'(f3),       32'd0);
    chk("arst.rd3",    32'(rd3),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst.rel.rd3",    32'(rd3), 32'd1);
    chk("arst.rel.saddr3", 32'(sa3), 32'd12);
    chk("arst.rel.rd0",    32'(rd0), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #2;
      chk($sformatf("arst.+%0d.ack3", k), 32'(out3.ack), (k == 4) ? 32'd1 : 32'd0);
      if (k == 1) begin
        chk("arst.+1.ack0",  32'(out0.ack), 32'd1);
        chk("arst.+1.data0", out0.r_data,   mem_val(0));
      end
    end
    chk("arst.data3", out3.r_data, mem_val(12));
    chk("arst.fault3.done", 32'(f3), 32'd0);

    in0.req = 1'b0;
    in3.req = 1'b0;
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
